// File: rtl/apb_regfile_slave_pkg.sv
// Shared types, widths and helpers for the APB register-file slave.
package apb_pkg;

   localparam int APB_ADDR_W = 8;
   localparam int IDX_W      = APB_ADDR_W - 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             err;
      logic             is_ro;
   } decode_t;

   function automatic int strb_w(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB v2.0 bus bundle (with pstrb/pslverr) shared by master and slave.
interface apb_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [DATA_W-1:0]     pwdata;
   logic [DATA_W/8-1:0]   pstrb;
   logic [DATA_W-1:0]     prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_regfile_slave_reg_bank.sv
// Register storage with byte-strobed writes, RO slots mapped to hw_status,
// a registered read port and one-hot write pulses.
module apb_reg_bank
   import apb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         go,
   input  logic                         wr,
   input  decode_t                      dec,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [strb_w(DATA_W)-1:0]    strb,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic [NUM_REGS-1:0]          wr_pulse,
   output logic [DATA_W-1:0]            rdata
);

   localparam int STRB_W = strb_w(DATA_W);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rd_val;

   // NOTE: every combinational output gets a default before the loop so no latch is inferred.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(dec.idx) == i)
            rd_val = dec.is_ro ? hw_status[i*DATA_W +: DATA_W] : regs[i];
      end
   end

   // NOTE: the storage array is reset because consumers of reg_q see it directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         wr_pulse <= '0;
         rdata    <= '0;
      end else begin
         wr_pulse <= '0;
         rdata    <= '0;
         if (go && !dec.err) begin
            if (wr) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (int'(dec.idx) == i) begin
                     wr_pulse[i] <= 1'b1;
                     for (int k = 0; k < STRB_W; k++)
                        if (strb[k]) regs[i][k*8 +: 8] <= wdata[k*8 +: 8];
                  end
               end
            end else begin
               rdata <= rd_val;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
      assign reg_q[g*DATA_W +: DATA_W] = regs[g];
   end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave front end: address decode, IDLE/WAIT/RESP handshake FSM and
// wait-state counter around a parametrised register bank.
module apb_regfile_slave
   import apb_pkg::*;
#(
   parameter int                  ADDR_W      = APB_ADDR_W,
   parameter int                  DATA_W      = 32,
   parameter int                  NUM_REGS    = 16,
   parameter int                  WAIT_STATES = 0,
   parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   apb_if.slave                       bus,
   output logic [NUM_REGS*DATA_W-1:0] reg_q,
   output logic [NUM_REGS-1:0]        wr_pulse,
   input  logic [NUM_REGS*DATA_W-1:0] hw_status
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_WAIT  = WAIT;
   localparam logic [1:0] ST_RESP  = RESP;
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [1:0]        state_q;
   logic [3:0]        cnt_q;
   logic [ADDR_W-3:0] addr_idx;
   decode_t           dec_d, dec_q, dec_cur;
   logic              wr_q, wr_cur;
   logic              start, go;
   logic              pready_q, pslverr_q;
   logic [DATA_W-1:0] prdata_q;

   always_comb begin
      addr_idx = bus.paddr[ADDR_W-1:2];
      dec_d    = '0;
      dec_d.idx = IDX_W'(addr_idx);
      for (int i = 0; i < NUM_REGS; i++)
         if (int'(addr_idx) == i) dec_d.is_ro = RO_MASK[i];
      dec_d.err = (bus.paddr[1:0] != 2'b00) || (int'(addr_idx) >= NUM_REGS) ||
                  (bus.pwrite && dec_d.is_ro);
   end

   // With no wait states the decode is consumed on the same edge it is latched.
   assign start   = (state_q == ST_IDLE) && bus.psel && bus.penable;
   assign go      = (start && (WAIT_STATES == 0)) ||
                    ((state_q == ST_WAIT) && bus.psel && (cnt_q == 4'd0));
   assign dec_cur = (state_q == ST_IDLE) ? dec_d : dec_q;
   assign wr_cur  = (state_q == ST_IDLE) ? bus.pwrite : wr_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         dec_q     <= '0;
         wr_q      <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         pready_q  <= go;
         pslverr_q <= go && dec_cur.err;
         case (state_q)
            ST_IDLE: if (start) begin
               dec_q <= dec_d;
               wr_q  <= bus.pwrite;
               if (WAIT_STATES > 0) begin
                  state_q <= ST_WAIT;
                  cnt_q   <= CNT_LOAD;
               end else begin
                  state_q <= ST_RESP;
               end
            end
            ST_WAIT: begin
               if (!bus.psel)            state_q <= ST_IDLE;
               else if (cnt_q == 4'd0)   state_q <= ST_RESP;
               else                      cnt_q   <= cnt_q - 4'd1;
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   apb_reg_bank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .go        (go),
      .wr        (wr_cur),
      .dec       (dec_cur),
      .wdata     (bus.pwdata),
      .strb      (bus.pstrb),
      .hw_status (hw_status),
      .reg_q     (reg_q),
      .wr_pulse  (wr_pulse),
      .rdata     (prdata_q)
   );

   assign bus.pready  = pready_q;
   assign bus.pslverr = pslverr_q;
   assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: one slave with no wait states and one with three, both
// with slot 15 read-only, sharing one master driver through a select mux.
module tb_apb_regfile_slave;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         dsel;
   logic         psel, penable, pwrite;
   logic [7:0]   paddr;
   logic [31:0]  pwdata;
   logic [3:0]   pstrb;
   logic [511:0] hw_status;

   logic         pready, pslverr;
   logic [31:0]  prdata;
   logic [15:0]  wr_pulse;
   logic [511:0] reg_q;

   logic [511:0] reg_q_a, reg_q_b;
   logic [15:0]  wr_pulse_a, wr_pulse_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   apb_if #(.ADDR_W(8), .DATA_W(32)) bus_a ();
   apb_if #(.ADDR_W(8), .DATA_W(32)) bus_b ();

   assign bus_a.psel    = psel & ~dsel;
   assign bus_b.psel    = psel & dsel;
   assign bus_a.penable = penable;
   assign bus_b.penable = penable;
   assign bus_a.pwrite  = pwrite;
   assign bus_b.pwrite  = pwrite;
   assign bus_a.paddr   = paddr;
   assign bus_b.paddr   = paddr;
   assign bus_a.pwdata  = pwdata;
   assign bus_b.pwdata  = pwdata;
   assign bus_a.pstrb   = pstrb;
   assign bus_b.pstrb   = pstrb;

   assign pready   = dsel ? bus_b.pready  : bus_a.pready;
   assign pslverr  = dsel ? bus_b.pslverr : bus_a.pslverr;
   assign prdata   = dsel ? bus_b.prdata  : bus_a.prdata;
   assign wr_pulse = dsel ? wr_pulse_b    : wr_pulse_a;
   assign reg_q    = dsel ? reg_q_b       : reg_q_a;

   apb_regfile_slave #(
      .ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_STATES(0), .RO_MASK(16'h8000)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a),
      .reg_q(reg_q_a), .wr_pulse(wr_pulse_a), .hw_status(hw_status)
   );

   apb_regfile_slave #(
      .ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_STATES(3), .RO_MASK(16'h8000)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b),
      .reg_q(reg_q_b), .wr_pulse(wr_pulse_b), .hw_status(hw_status)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] slot(input int i);
      return reg_q[i*32 +: 32];
   endfunction

   // One full transfer; returns the ack-cycle sample and whether the ack was a clean single pulse.
   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                           output int lat, output logic [15:0] wp, output logic pulse_ok);
      logic got;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk);
      lat = 0; got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         if (pready) got = 1'b1;
         else begin
            lat++;
            @(posedge clk);
         end
      end
      check("ack_seen", 32'(got), 32'd1);
      rdata = prdata; err = pslverr; wp = wr_pulse;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      pulse_ok = !pready && !pslverr && (prdata == 32'd0) && (wr_pulse == 16'd0);
   endtask

   task automatic watch(input int n, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (pready || (wr_pulse != 16'd0)) seen = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        err, ok, seen;
      logic [15:0] wp;
      int          lat;

      for (int i = 0; i < 16; i++) hw_status[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
      hw_status[15*32 +: 32] = 32'hCAFE_0001;
      rst_n = 1'b0; dsel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;

      repeat (2) @(negedge clk);
      check("rst_pready",   32'(pready),   32'd0);
      check("rst_pslverr",  32'(pslverr),  32'd0);
      check("rst_prdata",   prdata,        32'd0);
      check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      check("rst_slot1",    slot(1),       32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero wait states: full write, read-back and byte-strobed partial write.
      apb_xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, err, lat, wp, ok);
      check("w1_latency",  32'(lat), 32'd0);
      check("w1_pslverr",  32'(err), 32'd0);
      check("w1_wr_pulse", 32'(wp),  32'h0002);
      check("w1_pulse",    32'(ok),  32'd1);
      check("w1_slot1",    slot(1),  32'hDEADBEEF);

      apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, err, lat, wp, ok);
      check("r1_prdata",   rd,       32'hDEADBEEF);
      check("r1_pslverr",  32'(err), 32'd0);
      check("r1_wr_pulse", 32'(wp),  32'h0000);
      check("r1_pulse",    32'(ok),  32'd1);

      apb_xfer(1'b1, 8'h04, 32'h11223344, 4'h5, rd, err, lat, wp, ok);
      check("strb_slot1",  slot(1),  32'hDE22BE44);
      check("strb_wr_pulse", 32'(wp), 32'h0002);

      // Decode errors and the read-only status slot.
      apb_xfer(1'b0, 8'h40, 32'h0, 4'h0, rd, err, lat, wp, ok);
      check("oor_pslverr", 32'(err), 32'd1);
      check("oor_prdata",  rd,       32'd0);

      apb_xfer(1'b1, 8'h02, 32'h12345678, 4'hF, rd, err, lat, wp, ok);
      check("unal_pslverr",  32'(err), 32'd1);
      check("unal_wr_pulse", 32'(wp),  32'd0);
      check("unal_slot0",    slot(0),  32'd0);

      apb_xfer(1'b1, 8'h3C, 32'h55555555, 4'hF, rd, err, lat, wp, ok);
      check("ro_wr_pslverr",  32'(err), 32'd1);
      check("ro_wr_wr_pulse", 32'(wp),  32'd0);
      check("ro_wr_slot15",   slot(15), 32'd0);
      check("ro_wr_pulse",    32'(ok),  32'd1);

      apb_xfer(1'b0, 8'h3C, 32'h0, 4'h0, rd, err, lat, wp, ok);
      check("ro_rd_prdata",  rd,       32'hCAFE0001);
      check("ro_rd_pslverr", 32'(err), 32'd0);

      // Back-to-back writes with no idle cycle between transfers.
      apb_xfer(1'b1, 8'h00, 32'h000000AA, 4'hF, rd, err, lat, wp, ok);
      check("b2b1_latency",  32'(lat), 32'd0);
      check("b2b1_wr_pulse", 32'(wp),  32'h0001);
      check("b2b1_pulse",    32'(ok),  32'd1);
      apb_xfer(1'b1, 8'h08, 32'h000000BB, 4'hF, rd, err, lat, wp, ok);
      check("b2b2_latency",  32'(lat), 32'd0);
      check("b2b2_wr_pulse", 32'(wp),  32'h0004);
      check("b2b2_pulse",    32'(ok),  32'd1);
      watch(4, seen);
      check("b2b_no_third_ack", 32'(seen), 32'd0);
      check("b2b_slot0", slot(0), 32'h000000AA);
      check("b2b_slot2", slot(2), 32'h000000BB);

      // Three wait states: latency, then an aborted write.
      dsel = 1'b1;
      apb_xfer(1'b1, 8'h00, 32'h13579BDF, 4'hF, rd, err, lat, wp, ok);
      check("ws_w_latency",  32'(lat), 32'd3);
      check("ws_w_wr_pulse", 32'(wp),  32'h0001);
      apb_xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, err, lat, wp, ok);
      check("ws_r_latency", 32'(lat), 32'd3);
      check("ws_r_prdata",  rd,       32'h13579BDF);
      check("ws_r_pulse",   32'(ok),  32'd1);

      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
      watch(8, seen);
      check("abort_no_ack", 32'(seen), 32'd0);
      check("abort_slot0",  slot(0),   32'h13579BDF);

      // Reset asserted while a write sits in WAIT.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h12345678; pstrb = 4'hF;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check("arst_pready",   32'(pready),   32'd0);
      check("arst_pslverr",  32'(pslverr),  32'd0);
      check("arst_prdata",   prdata,        32'd0);
      check("arst_wr_pulse", 32'(wr_pulse), 32'd0);
      check("arst_slot0",    slot(0),       32'd0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      watch(6, seen);
      check("arst_no_ack", 32'(seen), 32'd0);
      check("arst_slot4",  slot(4),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
